// File: rtl/mastermind_pkg.sv
// Shared types and widths for the mastermind guesser and scorer.
package mastermind_pkg;

    localparam int PEG_W    = 3;
    localparam int NUM_PEGS = 4;
    localparam int CODE_W   = 12;
    localparam int FB_W     = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_PRESENT,
        S_SOLVED,
        S_FAILED
    } solver_state_t;

    typedef struct packed {
        logic [FB_W-1:0] red;
        logic [FB_W-1:0] white;
    } fb_t;

    typedef struct packed {
        logic [CODE_W-1:0] guess;
        fb_t               fb;
    } hist_entry_t;

endpackage

// File: rtl/mastermind_if.sv
// Guess/feedback handshake between the codebreaker (master) and the scoring side (slave).
interface mastermind_if;
    import mastermind_pkg::*;

    logic [CODE_W-1:0] guess;
    logic              guess_valid;
    logic              fb_valid;
    logic [FB_W-1:0]   red;
    logic [FB_W-1:0]   white;

    modport master (output guess, output guess_valid,
                    input fb_valid, input red, input white);
    modport slave  (input guess, input guess_valid,
                    output fb_valid, output red, output white);
endinterface

// File: rtl/mastermind_scorer.sv
// Combinational red/white scorer for two 4-peg codes; usable on either side of the game.
module mastermind_scorer
    import mastermind_pkg::*;
(
    input  logic [CODE_W-1:0] a,
    input  logic [CODE_W-1:0] b,
    output logic [FB_W-1:0]   red,
    output logic [FB_W-1:0]   white
);
    logic [2:0] na [8];
    logic [2:0] nb [8];
    logic [2:0] red_cnt;
    logic [2:0] common;

    // Positional matches, per-colour counts, and colour overlap.
    always_comb begin
        red_cnt = 3'd0;
        common  = 3'd0;
        for (int c = 0; c < 8; c++) begin
            na[c] = 3'd0;
            nb[c] = 3'd0;
        end
        for (int p = 0; p < NUM_PEGS; p++) begin
            if (a[p*PEG_W +: PEG_W] == b[p*PEG_W +: PEG_W])
                red_cnt = red_cnt + 3'd1;
            for (int c = 0; c < 8; c++) begin
                if (a[p*PEG_W +: PEG_W] == 3'(c)) na[c] = na[c] + 3'd1;
                if (b[p*PEG_W +: PEG_W] == 3'(c)) nb[c] = nb[c] + 3'd1;
            end
        end
        for (int c = 0; c < 8; c++)
            common = common + ((na[c] < nb[c]) ? na[c] : nb[c]);
    end

    assign red   = red_cnt;
    assign white = common - red_cnt;

endmodule

// File: rtl/mastermind_solver.sv
// Automatic codebreaker: proposes the next candidate (ascending, wrapping) that is
// consistent with every recorded guess/feedback pair.
// Optional feature macro: SOLVER_STATS_EN builds the search_cycles counter.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  S_IDLE    | after reset, waiting for start
//  S_SEARCH  | testing cand against one history entry per cycle
//  S_PRESENT | cand on the guess bus, waiting for feedback
//  S_SOLVED  | last feedback was red=4
//  S_FAILED  | guess budget spent, or no candidate fits (err_inconsistent)
module mastermind_solver
    import mastermind_pkg::*;
#(
    parameter int                MAX_GUESSES = 10,
    parameter logic [CODE_W-1:0] FIRST_GUESS = 12'o0011
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    mastermind_if.master         bus,
    output logic [3:0]           guess_count,
    output logic                 busy,
    output logic                 solved,
    output logic                 failed,
    output logic                 err_inconsistent,
    output logic [15:0]          search_cycles
);
    solver_state_t     state;
    logic [CODE_W-1:0] cand;
    logic [12:0]       tried;
    logic [3:0]        idx;
    logic [3:0]        hist_cnt;
    hist_entry_t       hist [MAX_GUESSES];
    hist_entry_t       sel;
    logic [FB_W-1:0]   sc_red;
    logic [FB_W-1:0]   sc_white;
    logic              fb_match;
    logic              last_idx;
    logic [3:0]        count_next;
    logic              can_start;

    // Select the history entry currently being checked.
    always_comb begin
        sel = '0;
        for (int i = 0; i < MAX_GUESSES; i++)
            if (idx == 4'(i)) sel = hist[i];
    end

    mastermind_scorer u_scorer (
        .a     (cand),
        .b     (sel.guess),
        .red   (sc_red),
        .white (sc_white)
    );

    assign fb_match   = (sc_red == sel.fb.red) && (sc_white == sel.fb.white);
    assign last_idx   = (idx == hist_cnt - 4'd1);
    assign count_next = guess_count + 4'd1;
    assign can_start  = (state == S_IDLE) || (state == S_SOLVED) || (state == S_FAILED);

    assign busy   = (state == S_SEARCH) || (state == S_PRESENT);
    assign solved = (state == S_SOLVED);
    assign failed = (state == S_FAILED);

    // Game FSM: candidate search, guess presentation and history capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            cand             <= '0;
            tried            <= '0;
            idx              <= '0;
            hist_cnt         <= '0;
            guess_count      <= '0;
            err_inconsistent <= 1'b0;
            bus.guess        <= '0;
            bus.guess_valid  <= 1'b0;
            for (int i = 0; i < MAX_GUESSES; i++) hist[i] <= '0;
        end else begin
            case (state)
                S_IDLE, S_SOLVED, S_FAILED: begin
                    if (start) begin
                        state            <= S_SEARCH;
                        cand             <= FIRST_GUESS;
                        hist_cnt         <= '0;
                        idx              <= '0;
                        tried            <= '0;
                        guess_count      <= '0;
                        err_inconsistent <= 1'b0;
                    end
                end
                S_SEARCH: begin
                    if (tried[12]) begin
                        state            <= S_FAILED;
                        err_inconsistent <= 1'b1;
                    end else if (hist_cnt == 4'd0) begin
                        state           <= S_PRESENT;
                        bus.guess       <= cand;
                        bus.guess_valid <= 1'b1;
                    end else if (!fb_match) begin
                        cand  <= cand + 12'd1;
                        tried <= tried + 13'd1;
                        idx   <= '0;
                        // The last untried code just failed: the history is unsatisfiable.
                        if (tried == 13'd4095) begin
                            state            <= S_FAILED;
                            err_inconsistent <= 1'b1;
                        end
                    end else if (last_idx) begin
                        state           <= S_PRESENT;
                        bus.guess       <= cand;
                        bus.guess_valid <= 1'b1;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                S_PRESENT: begin
                    if (bus.fb_valid) begin
                        for (int i = 0; i < MAX_GUESSES; i++)
                            if (hist_cnt == 4'(i))
                                hist[i] <= '{guess: cand, fb: '{red: bus.red, white: bus.white}};
                        hist_cnt        <= hist_cnt + 4'd1;
                        guess_count     <= count_next;
                        bus.guess_valid <= 1'b0;
                        if (bus.red == 3'd4) begin
                            state <= S_SOLVED;
                        end else if (count_next == 4'(MAX_GUESSES)) begin
                            state            <= S_FAILED;
                            err_inconsistent <= 1'b0;
                        end else begin
                            state <= S_SEARCH;
                            cand  <= cand + 12'd1;
                            tried <= tried + 13'd1;
                            idx   <= '0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SOLVER_STATS_EN
    logic [15:0] stat_q;

    // Saturating count of SEARCH cycles in the current game.
    always_ff @(posedge clk) begin
        if (reset)
            stat_q <= '0;
        else if (start && can_start)
            stat_q <= '0;
        else if ((state == S_SEARCH) && (stat_q != 16'hFFFF))
            stat_q <= stat_q + 16'd1;
    end

    assign search_cycles = stat_q;
`else
    assign search_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_mastermind_solver.sv
// Self-checking bench for mastermind_solver: closed-loop games against a reference
// scorer/candidate model, plus reset, override and robustness scenarios.
module tb_mastermind_solver;
    import mastermind_pkg::*;

    localparam int MAXG = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, start2;
    logic [3:0]  gc, gc2;
    logic        busy, solved, failed, err;
    logic        busy2, solved2, failed2, err2;
    logic [15:0] sc, sc2;

    mastermind_if u_if ();
    mastermind_if u_if2 ();

    mastermind_solver #(.MAX_GUESSES(MAXG)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(u_if.master),
        .guess_count(gc), .busy(busy), .solved(solved), .failed(failed),
        .err_inconsistent(err), .search_cycles(sc)
    );

    mastermind_solver #(.MAX_GUESSES(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .bus(u_if2.master),
        .guess_count(gc2), .busy(busy2), .solved(solved2), .failed(failed2),
        .err_inconsistent(err2), .search_cycles(sc2)
    );

    int checks = 0;
    int errors = 0;

    int hg[$];
    int hr[$];
    int hw[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mastermind scoring from the rules: positional hits, then colour overlap minus hits.
    function automatic void ref_score(input int a, input int b, output int r, output int w);
        int na[8];
        int nb[8];
        int common;
        r = 0;
        common = 0;
        for (int c = 0; c < 8; c++) begin na[c] = 0; nb[c] = 0; end
        for (int i = 0; i < 4; i++) begin
            int da, db;
            da = (a >> (3*i)) & 7;
            db = (b >> (3*i)) & 7;
            if (da == db) r++;
            na[da]++;
            nb[db]++;
        end
        for (int c = 0; c < 8; c++) common += (na[c] < nb[c]) ? na[c] : nb[c];
        w = common - r;
    endfunction

    function automatic bit consistent(input int c);
        int r, w;
        for (int i = 0; i < hg.size(); i++) begin
            ref_score(c, hg[i], r, w);
            if (r != hr[i] || w != hw[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int next_cand(input int from);
        for (int k = 0; k < 4096; k++) begin
            int c;
            c = (from + k) % 4096;
            if (consistent(c)) return c;
        end
        return from;
    endfunction

    task automatic wait_valid(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50000; i++) begin
            if ((which == 1) ? u_if.guess_valid : u_if2.guess_valid) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_guess"},  32'(u_if.guess), 32'd0);
        check_val({tag, "_gvalid"}, 32'(u_if.guess_valid), 32'd0);
        check_val({tag, "_count"},  32'(gc), 32'd0);
        check_val({tag, "_busy"},   32'(busy), 32'd0);
        check_val({tag, "_solved"}, 32'(solved), 32'd0);
        check_val({tag, "_failed"}, 32'(failed), 32'd0);
        check_val({tag, "_err"},    32'(err), 32'd0);
        check_val({tag, "_stats"},  32'(sc), 32'd0);
    endtask

    task automatic play_game(input int secret, input bit inject);
        int  exp_g, g, r, w, n;
        bit  ok;
        hg.delete(); hr.delete(); hw.delete();
        start = 1'b1; tick(); start = 1'b0;
        exp_g = 12'o0011;
        n = 0;
        for (int k = 0; k <= MAXG; k++) begin
            wait_valid(1, ok);
            check_val("guess_wait", 32'(ok), 32'd1);
            if (!ok) return;
            g = int'(u_if.guess);
            check_val("guess", 32'(g), 32'(exp_g));
            check_val("guess_fits_history", 32'(consistent(g)), 32'd1);
            if (n == 1 && hr[0] == 0 && hw[0] == 0)
                check_val("guess_after_zero_fb", 32'(g), 32'o2222);
            ref_score(g, secret, r, w);
            u_if.red = 3'(r); u_if.white = 3'(w); u_if.fb_valid = 1'b1;
            tick();
            u_if.fb_valid = 1'b0;
            hg.push_back(g); hr.push_back(r); hw.push_back(w);
            n++;
            check_val("guess_count", 32'(gc), 32'(n));
            check_val("gvalid_fall", 32'(u_if.guess_valid), 32'd0);
            if (r == 4) begin
                check_val("solved", 32'(solved), 32'd1);
                check_val("busy_end", 32'(busy), 32'd0);
                return;
            end
            if (n == MAXG) begin
                check_val("fail_budget", 32'(failed), 32'd1);
                check_val("fail_budget_err", 32'(err), 32'd0);
                return;
            end
            if (inject && n == 1) begin
                u_if.red = 3'd4; u_if.white = 3'd0; u_if.fb_valid = 1'b1;
                tick();
                u_if.fb_valid = 1'b0;
                check_val("search_fb_ignored_solved", 32'(solved), 32'd0);
                check_val("search_fb_ignored_count", 32'(gc), 32'(n));
            end
            exp_g = next_cand(g + 1);
        end
    endtask

    initial begin
        bit ok;
        reset = 1'b1; start = 1'b0; start2 = 1'b0;
        u_if.fb_valid = 1'b0; u_if.red = '0; u_if.white = '0;
        u_if2.fb_valid = 1'b0; u_if2.red = '0; u_if2.white = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check_idle("reset");

        start = 1'b1; tick(); start = 1'b0;
        check_val("gvalid_1cyc", 32'(u_if.guess_valid), 32'd0);
        tick();
        check_val("gvalid_2cyc", 32'(u_if.guess_valid), 32'd1);
        check_val("first_guess", 32'(u_if.guess), 32'o0011);

        start = 1'b1; tick(); start = 1'b0;
        check_val("start_in_present_gv", 32'(u_if.guess_valid), 32'd1);
        check_val("start_in_present_guess", 32'(u_if.guess), 32'o0011);
        check_val("start_in_present_busy", 32'(busy), 32'd1);

        reset = 1'b1; tick(); reset = 1'b0;
        check_idle("midreset");

        play_game(12'o0011, 1'b0);
        play_game(12'o2345, 1'b0);
        play_game(12'o7654, 1'b1);
`ifdef SOLVER_STATS_EN
        check_val("stats_nonzero", 32'(sc != 16'd0), 32'd1);
`else
        check_val("stats_zero", 32'(sc), 32'd0);
`endif
        play_game(12'o0000, 1'b0);
        play_game(12'o7777, 1'b0);
        play_game(12'o1234, 1'b0);
        play_game(int'($urandom_range(0, 4095)), 1'b1);
        play_game(int'($urandom_range(0, 4095)), 1'b0);

        // Impossible feedback exhausts the code space.
        start = 1'b1; tick(); start = 1'b0;
        wait_valid(1, ok);
        check_val("inc_wait", 32'(ok), 32'd1);
        u_if.red = 3'd3; u_if.white = 3'd1; u_if.fb_valid = 1'b1;
        tick();
        u_if.fb_valid = 1'b0;
        for (int i = 0; i < 4100; i++) begin
            if (failed) break;
            tick();
        end
        check_val("inc_failed", 32'(failed), 32'd1);
        check_val("inc_err", 32'(err), 32'd1);
        check_val("inc_count", 32'(gc), 32'd1);
        check_val("inc_busy", 32'(busy), 32'd0);

        // Two-guess budget on the overridden instance.
        start2 = 1'b1; tick(); start2 = 1'b0;
        wait_valid(2, ok);
        check_val("max2_wait1", 32'(ok), 32'd1);
        u_if2.red = 3'd0; u_if2.white = 3'd0; u_if2.fb_valid = 1'b1;
        tick();
        u_if2.fb_valid = 1'b0;
        wait_valid(2, ok);
        check_val("max2_wait2", 32'(ok), 32'd1);
        check_val("max2_guess2", 32'(u_if2.guess), 32'o2222);
        u_if2.fb_valid = 1'b1;
        tick();
        u_if2.fb_valid = 1'b0;
        check_val("max2_failed", 32'(failed2), 32'd1);
        check_val("max2_err", 32'(err2), 32'd0);
        check_val("max2_count", 32'(gc2), 32'd2);
        check_val("max2_gvalid", 32'(u_if2.guess_valid), 32'd0);
        check_val("max2_guess_hold", 32'(u_if2.guess), 32'o2222);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
